uart_msg_scheduler: RTL and testbench

- Shares the single string-sending UART TX path among several requesters: game-state FSM, pattern-judgement logic, pause/restart control and score reporting.
- Each requester posts a message code. The block holds one pending code per source and arbitrates round-robin.
- It drives a one-cycle start plus a stable code to the string sender, then waits for completion or a timeout.
- It enforces an inter-message gap before issuing the next grant.

---
 rtl/uart_msg_scheduler.sv | 160 ++++++++++++++++
 tb/tb_uart_msg_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_scheduler.sv
// Round-robin scheduler that shares one string-sending UART TX path among NUM_SRC requesters.
// Holds one pending message code per source, issues a start pulse, then waits for done or a timeout.
module uart_msg_scheduler #(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned CODE_W      = 4,
  parameter int unsigned TIMEOUT_CYC = 2000000,
  parameter int unsigned GAP_CYC     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         req_valid,
  input  logic [NUM_SRC*CODE_W-1:0]  req_code,
  output logic [NUM_SRC-1:0]         pending,
  output logic [NUM_SRC-1:0]         req_drop,
  output logic                       msg_start,
  output logic [CODE_W-1:0]          msg_code,
  output logic [$clog2(NUM_SRC)-1:0] grant_src,
  output logic                       msg_busy,
  input  logic                       msg_done,
  output logic                       timeout_err
);

  localparam int unsigned SRC_W = $clog2(NUM_SRC);
  localparam int unsigned TO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned GAP_W = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [SRC_W-1:0] SRC_LAST = SRC_W'(NUM_SRC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam state_t AFTER_WAIT = (GAP_CYC == 0) ? S_IDLE : S_GAP;

  state_t                         state_q, state_d;
  logic [NUM_SRC-1:0]             pending_q, pending_d;
  logic [NUM_SRC-1:0][CODE_W-1:0] slot_q, slot_d;
  logic [NUM_SRC-1:0]             drop_q, drop_d;
  logic [SRC_W-1:0]               rr_q, rr_d;
  logic [CODE_W-1:0]              code_q, code_d;
  logic [SRC_W-1:0]               src_q, src_d;
  logic [TO_W-1:0]                to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]               gap_cnt_q, gap_cnt_d;

  logic                           found;
  logic [SRC_W-1:0]               win;
  logic [SRC_W-1:0]               scan_idx;
  logic                           grant;

  // Rotating priority search starting at the round-robin pointer.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      scan_idx = SRC_W'((32'(rr_q) + k) % NUM_SRC);
      if (!found && pending_q[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    slot_d      = slot_q;
    drop_d      = '0;
    rr_d        = rr_q;
    code_d      = code_q;
    src_d       = src_q;
    to_cnt_d    = to_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    timeout_err = 1'b0;
    grant       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          grant          = 1'b1;
          state_d        = S_ISSUE;
          rr_d           = (win == SRC_LAST) ? '0 : win + SRC_W'(1);
          code_d         = slot_q[win];
          src_d          = win;
          pending_d[win] = 1'b0;
        end
      end
      S_ISSUE: begin
        to_cnt_d = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (msg_done) begin
          state_d   = AFTER_WAIT;
          gap_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_err = 1'b1;
          state_d     = AFTER_WAIT;
          gap_cnt_d   = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Runs after the grant so a same-cycle request refills the slot the grant just emptied.
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (req_valid[i]) begin
        slot_d[i]    = req_code[i*CODE_W +: CODE_W];
        drop_d[i]    = pending_q[i] && !(grant && (32'(win) == i));
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      slot_q    <= '0;
      drop_q    <= '0;
      rr_q      <= '0;
      code_q    <= '0;
      src_q     <= '0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      slot_q    <= slot_d;
      drop_q    <= drop_d;
      rr_q      <= rr_d;
      code_q    <= code_d;
      src_q     <= src_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign pending   = pending_q;
  assign req_drop  = drop_q;
  assign msg_start = (state_q == S_ISSUE);
  assign msg_busy  = (state_q != S_IDLE);
  assign msg_code  = code_q;
  assign grant_src = src_q;

endmodule

// File: tb/tb_uart_msg_scheduler.sv
// Directed bench for uart_msg_scheduler: cycle-exact checks of grant order, overwrite,
// timeout, done/timeout collision and reset behaviour with hand-computed cycle numbers.
module tb_uart_msg_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_code = '0;
  logic [3:0]  pending;
  logic [3:0]  req_drop;
  logic        msg_start;
  logic [3:0]  msg_code;
  logic [1:0]  grant_src;
  logic        msg_busy;
  logic        msg_done = 1'b0;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int         st_cyc[$];
  logic [3:0] st_code[$];
  logic [1:0] st_src[$];
  int         to_cyc[$];
  int         drop_total = 0;

  uart_msg_scheduler #(
    .NUM_SRC    (4),
    .CODE_W     (4),
    .TIMEOUT_CYC(100),
    .GAP_CYC    (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_code   (req_code),
    .pending    (pending),
    .req_drop   (req_drop),
    .msg_start  (msg_start),
    .msg_code   (msg_code),
    .grant_src  (grant_src),
    .msg_busy   (msg_busy),
    .msg_done   (msg_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled mid-cycle; cycle index equals the number of rising edges so far.
  always @(negedge clk) begin
    if (msg_start) begin
      st_cyc.push_back(cyc);
      st_code.push_back(msg_code);
      st_src.push_back(grant_src);
    end
    if (timeout_err) to_cyc.push_back(cyc);
    drop_total = drop_total + $countones(req_drop);
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic pulse(input logic [3:0] mask, input logic [15:0] code);
    req_valid = mask;
    req_code  = code;
    step();
    req_valid = '0;
    req_code  = '0;
  endtask

  task automatic done_pulse();
    msg_done = 1'b1;
    step();
    msg_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pending"}, 32'(pending), 0);
    check({tag, "_drop"},    32'(req_drop), 0);
    check({tag, "_start"},   32'(msg_start), 0);
    check({tag, "_code"},    32'(msg_code), 0);
    check({tag, "_src"},     32'(grant_src), 0);
    check({tag, "_busy"},    32'(msg_busy), 0);
    check({tag, "_tmo"},     32'(timeout_err), 0);
  endtask

  // Waits for each start, then answers with done `hold` cycles later.
  task automatic serve(input int n, input int hold);
    for (int m = 0; m < n; m++) begin
      int b = 0;
      while (!msg_start && b < 300) begin
        step();
        b++;
      end
      check("serve_start_seen", 32'(msg_start), 1);
      repeat (hold) step();
      done_pulse();
    end
  endtask

  initial begin
    // Reset values
    goto(2);
    check_all_zero("rst");
    goto(3);
    reset = 1'b0;

    // Single request: src1 code 6 in cycle 10
    st_cyc.delete(); st_code.delete(); st_src.delete();
    goto(10);
    pulse(4'b0010, 16'h0060);
    check("single_pending", 32'(pending), 32'h2);
    check("single_start_early", 32'(msg_start), 0);
    goto(12);
    check("single_start", 32'(msg_start), 1);
    check("single_code", 32'(msg_code), 6);
    check("single_src", 32'(grant_src), 1);
    check("single_pend_clr", 32'(pending), 0);
    check("single_busy", 32'(msg_busy), 1);
    goto(40);
    done_pulse();
    goto(56);
    check("single_busy_gap", 32'(msg_busy), 1);
    goto(57);
    check("single_busy_fall", 32'(msg_busy), 0);
    check("single_nstart", st_cyc.size(), 1);
    check("single_start_cyc", st_cyc[0], 12);

    // Reset to put the round-robin pointer back at 0
    goto(60);
    reset = 1'b1;
    goto(63);
    reset = 1'b0;

    // Round-robin: all four, codes 1..4
    st_cyc.delete(); st_code.delete(); st_src.delete();
    goto(70);
    pulse(4'b1111, 16'h4321);
    check("rr_pending_all", 32'(pending), 32'hF);
    serve(4, 5);
    goto(170);
    pulse(4'b1001, 16'hB00A);
    serve(2, 5);
    check("rr_nstart", st_cyc.size(), 6);
    for (int m = 0; m < 4; m++) begin
      check("rr_cyc", st_cyc[m], 32'(72 + 23 * m));
      check("rr_code", 32'(st_code[m]), 32'(m + 1));
      check("rr_src", 32'(st_src[m]), 32'(m));
    end
    check("rr2_cyc0", st_cyc[4], 172);
    check("rr2_code0", 32'(st_code[4]), 32'hA);
    check("rr2_src0", 32'(st_src[4]), 0);
    check("rr2_cyc1", st_cyc[5], 195);
    check("rr2_code1", 32'(st_code[5]), 32'hB);
    check("rr2_src1", 32'(st_src[5]), 3);

    // Overwrite while busy, then same-cycle-as-grant refill
    st_cyc.delete(); st_code.delete(); st_src.delete();
    goto(230);
    pulse(4'b0001, 16'h0001);
    goto(235);
    pulse(4'b0100, 16'h0500);
    check("ovw_pending", 32'(pending), 32'h4);
    check("ovw_nodrop_first", 32'(req_drop), 0);
    goto(240);
    pulse(4'b0100, 16'h0900);
    check("ovw_drop", 32'(req_drop), 32'h4);
    step();
    check("ovw_drop_once", 32'(req_drop), 0);
    goto(250);
    done_pulse();
    goto(266);
    check("ovw_gap_busy", 32'(msg_busy), 1);
    goto(267);
    pulse(4'b0100, 16'h0700);
    check("ovw_start", 32'(msg_start), 1);
    check("ovw_code", 32'(msg_code), 9);
    check("ovw_src", 32'(grant_src), 2);
    check("ovw_refill", 32'(pending), 32'h4);
    check("ovw_refill_nodrop", 32'(req_drop), 0);
    goto(270);
    done_pulse();
    goto(288);
    check("ovw2_start", 32'(msg_start), 1);
    check("ovw2_code", 32'(msg_code), 7);
    check("ovw2_src", 32'(grant_src), 2);
    check("ovw2_pending", 32'(pending), 0);
    goto(290);
    done_pulse();
    goto(310);
    check("ovw_nstart", st_cyc.size(), 3);
    check("ovw_first_cyc", st_cyc[0], 232);
    check("ovw_drop_total", drop_total, 1);

    // Timeout: src3 (pointer at 3) never completes, then src1 served
    st_cyc.delete(); st_code.delete(); st_src.delete(); to_cyc.delete();
    goto(320);
    pulse(4'b1010, 16'hC030);
    goto(322);
    check("tmo_start", 32'(msg_start), 1);
    check("tmo_src", 32'(grant_src), 3);
    goto(421);
    check("tmo_not_yet", 32'(timeout_err), 0);
    check("tmo_code_stable", 32'(msg_code), 32'hC);
    goto(422);
    check("tmo_pulse", 32'(timeout_err), 1);
    goto(423);
    check("tmo_pulse_end", 32'(timeout_err), 0);
    check("tmo_gap_busy", 32'(msg_busy), 1);
    goto(440);
    check("tmo_next_start", 32'(msg_start), 1);
    check("tmo_next_code", 32'(msg_code), 3);
    check("tmo_next_src", 32'(grant_src), 1);
    goto(445);
    done_pulse();
    goto(462);
    check("tmo_idle", 32'(msg_busy), 0);
    check("tmo_count", to_cyc.size(), 1);
    check("tmo_cyc", to_cyc[0], 422);

    // Done on the timeout cycle, then a spurious done in IDLE
    st_cyc.delete(); st_code.delete(); st_src.delete(); to_cyc.delete();
    goto(470);
    pulse(4'b0001, 16'h000E);
    goto(572);
    msg_done = 1'b1;
    #1;
    check("col_no_tmo", 32'(timeout_err), 0);
    step();
    msg_done = 1'b0;
    goto(588);
    check("col_gap_busy", 32'(msg_busy), 1);
    goto(589);
    check("col_idle", 32'(msg_busy), 0);
    goto(595);
    done_pulse();
    check("spur_busy", 32'(msg_busy), 0);
    check("spur_start", 32'(msg_start), 0);
    goto(605);
    check("col_tmo_count", to_cyc.size(), 0);
    check("col_nstart", st_cyc.size(), 1);
    check("col_start_cyc", st_cyc[0], 472);
    check("hold_code", 32'(msg_code), 32'hE);
    check("hold_src", 32'(grant_src), 0);

    // Reset mid-WAIT with two sources pending
    st_cyc.delete(); st_code.delete(); st_src.delete();
    goto(610);
    pulse(4'b0010, 16'h0020);
    goto(615);
    pulse(4'b1100, 16'h5400);
    check("rstw_pending", 32'(pending), 32'hC);
    check("rstw_busy", 32'(msg_busy), 1);
    goto(620);
    reset = 1'b1;
    #1;
    check("rstw_async_busy", 32'(msg_busy), 0);
    goto(621);
    check_all_zero("rstw");
    goto(623);
    reset = 1'b0;
    goto(660);
    check("rstw_nstart", st_cyc.size(), 1);
    check("rstw_idle", 32'(msg_busy), 0);
    check("rstw_pend_after", 32'(pending), 0);
    goto(665);
    pulse(4'b1000, 16'hF000);
    goto(667);
    check("rstw_new_start", 32'(msg_start), 1);
    check("rstw_new_code", 32'(msg_code), 32'hF);
    check("rstw_new_src", 32'(grant_src), 3);
    goto(670);
    done_pulse();
    goto(690);
    check("end_idle", 32'(msg_busy), 0);
    check("end_drop_total", drop_total, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
